// File: rtl/alu_param.sv
// Parametrised register ALU: A/B operand registers, ACC/ACCH accumulators, op valid/busy
// handshake and a multi-cycle shift-add multiplier.
module alu_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Op_valid,
  input  logic [3:0]       ALU_op,
  input  logic [WIDTH-1:0] InData,
  output logic             Busy,
  output logic             Done,
  output logic             Op_drop,
  output logic [WIDTH-1:0] OutData,
  output logic             Out_valid,
  output logic             FlagZ,
  output logic             FlagC,
  output logic             FlagN,
  output logic             FlagE
);

  localparam logic [3:0] OP_LDA    = 4'd1;
  localparam logic [3:0] OP_LDB    = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_AND    = 4'd5;
  localparam logic [3:0] OP_OR     = 4'd6;
  localparam logic [3:0] OP_XOR    = 4'd7;
  localparam logic [3:0] OP_OEACC  = 4'd8;
  localparam logic [3:0] OP_SHL    = 4'd9;
  localparam logic [3:0] OP_SHR    = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;
  localparam logic [3:0] OP_OEACCH = 4'd12;
  localparam logic [3:0] OP_CMP    = 4'd13;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acch_q;
  logic [WIDTH-1:0]   mreg_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic [WIDTH:0]     add_res;
  logic [WIDTH:0]     sub_res;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_upd;
  logic               res_c_upd;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;

  // Single-cycle datapath result and which flags it is allowed to touch
  always_comb begin
    accept    = Op_valid && !Busy;
    add_res   = {1'b0, a_q} + {1'b0, b_q};
    sub_res   = {1'b0, a_q} - {1'b0, b_q};
    res       = '0;
    res_c     = FlagC;
    res_upd   = 1'b0;
    res_c_upd = 1'b0;
    case (ALU_op)
      OP_ADD: begin res = add_res[WIDTH-1:0]; res_c = add_res[WIDTH]; res_upd = 1'b1; res_c_upd = 1'b1; end
      OP_SUB: begin res = sub_res[WIDTH-1:0]; res_c = sub_res[WIDTH]; res_upd = 1'b1; res_c_upd = 1'b1; end
      OP_AND: begin res = a_q & b_q; res_upd = 1'b1; end
      OP_OR:  begin res = a_q | b_q; res_upd = 1'b1; end
      OP_XOR: begin res = a_q ^ b_q; res_upd = 1'b1; end
      OP_SHL: begin res = a_q << 1; res_c = a_q[WIDTH-1]; res_upd = 1'b1; res_c_upd = 1'b1; end
      OP_SHR: begin res = a_q >> 1; res_c = a_q[0]; res_upd = 1'b1; res_c_upd = 1'b1; end
      default: ;
    endcase
  end

  // One shift-add step: add multiplicand into the high half, then shift {carry,ACCH,ACC} right
  always_comb begin
    mul_sum = {1'b0, acch_q} + (mreg_q[0] ? {1'b0, a_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      acch_q    <= '0;
      mreg_q    <= '0;
      cnt_q     <= '0;
      OutData   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Op_drop   <= 1'b0;
      Out_valid <= 1'b0;
      FlagZ     <= 1'b0;
      FlagC     <= 1'b0;
      FlagN     <= 1'b0;
      FlagE     <= 1'b0;
    end else begin
      Done      <= 1'b0;
      Out_valid <= 1'b0;
      Op_drop   <= Op_valid && Busy;
      case (state_q)
        MUL_RUN: begin
          acch_q <= mul_hi;
          acc_q  <= mul_lo;
          mreg_q <= mreg_q >> 1;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= MUL_DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            FlagZ   <= ({mul_hi, mul_lo} == '0);
            FlagN   <= mul_hi[WIDTH-1];
            FlagC   <= |mul_hi;
          end
        end
        default: begin
          // MUL_DONE lasts one cycle and accepts ops exactly like IDLE
          state_q <= IDLE;
          if (accept) begin
            if (res_upd) begin
              acc_q <= res;
              FlagZ <= (res == '0);
              FlagN <= res[WIDTH-1];
            end
            if (res_c_upd) FlagC <= res_c;
            case (ALU_op)
              OP_LDA:    a_q <= InData;
              OP_LDB:    b_q <= InData;
              OP_CMP:    FlagE <= (a_q == b_q);
              OP_OEACC:  begin OutData <= acc_q;  Out_valid <= 1'b1; end
              OP_OEACCH: begin OutData <= acch_q; Out_valid <= 1'b1; end
              OP_MUL: begin
                acc_q   <= '0;
                acch_q  <= '0;
                mreg_q  <= b_q;
                cnt_q   <= '0;
                Busy    <= 1'b1;
                state_q <= MUL_RUN;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param: WIDTH=8 and WIDTH=16 instances, output bus checked
// against a queue of expected OutData values.
module tb_alu_param;

  localparam logic [3:0] NOP = 4'd0, LDA = 4'd1, LDB = 4'd2, ADD = 4'd3, SUB = 4'd4;
  localparam logic [3:0] ANDO = 4'd5, ORO = 4'd6, XORO = 4'd7, OEACC = 4'd8, SHL = 4'd9;
  localparam logic [3:0] SHR = 4'd10, MUL = 4'd11, OEACCH = 4'd12, CMP = 4'd13, NOP15 = 4'd15;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  logic       v8 = 1'b0;
  logic [3:0] op8 = 4'd0;
  logic [7:0] d8 = 8'd0;
  logic       busy8, done8, drop8, ov8, z8, c8, n8, e8;
  logic [7:0] out8;

  logic        v16 = 1'b0;
  logic [3:0]  op16 = 4'd0;
  logic [15:0] d16 = 16'd0;
  logic        busy16, done16, drop16, ov16, z16, c16, n16, e16;
  logic [15:0] out16;

  int errors = 0;
  int checks = 0;
  logic [15:0] q8[$];
  logic [15:0] q16[$];

  always #5 Clk = ~Clk;

  alu_param #(.WIDTH(8)) u8 (
    .Clk(Clk), .Rst(Rst), .Op_valid(v8), .ALU_op(op8), .InData(d8),
    .Busy(busy8), .Done(done8), .Op_drop(drop8), .OutData(out8), .Out_valid(ov8),
    .FlagZ(z8), .FlagC(c8), .FlagN(n8), .FlagE(e8)
  );

  alu_param #(.WIDTH(16)) u16 (
    .Clk(Clk), .Rst(Rst), .Op_valid(v16), .ALU_op(op16), .InData(d16),
    .Busy(busy16), .Done(done16), .Op_drop(drop16), .OutData(out16), .Out_valid(ov16),
    .FlagZ(z16), .FlagC(c16), .FlagN(n16), .FlagE(e16)
  );

  // Scoreboard: every Out_valid pops one expected value
  always @(negedge Clk) begin
    if (!Rst && ov8 === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL out8_unexpected OutData=%h with empty queue", out8);
      end else begin
        logic [15:0] exp8;
        exp8 = q8.pop_front();
        if (out8 !== exp8[7:0]) begin
          errors++;
          $display("FAIL out8 got=%h exp=%h", out8, exp8[7:0]);
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (!Rst && ov16 === 1'b1) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL out16_unexpected OutData=%h with empty queue", out16);
      end else begin
        logic [15:0] exp16;
        exp16 = q16.pop_front();
        if (out16 !== exp16) begin
          errors++;
          $display("FAIL out16 got=%h exp=%h", out16, exp16);
        end
      end
    end
  end

  task automatic issue(input bit w16, input logic [3:0] op, input logic [15:0] d);
    @(negedge Clk);
    if (w16) begin v16 = 1'b1; op16 = op; d16 = d; end
    else begin v8 = 1'b1; op8 = op; d8 = d[7:0]; end
    @(posedge Clk);
    #1;
    v8 = 1'b0;
    v16 = 1'b0;
  endtask

  task automatic wait_done(input bit w16, output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (((w16 ? done16 : done8) !== 1'b1) && cyc < 60) begin
      if ((w16 ? busy16 : busy8) === 1'b1) busy_n++;
      @(posedge Clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy8, done8, drop8, ov8} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {busy8, done8, drop8, ov8});
    end
    checks++;
    if ({z8, c8, n8, e8} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {z8, c8, n8, e8});
    end
    checks++;
    if (out8 !== 8'h00 || out16 !== 16'h0000) begin
      errors++; $display("FAIL reset_outdata got=%h/%h exp=00/0000", out8, out16);
    end
  endtask

  task automatic test_add;
    issue(0, LDA, 16'hFF);
    issue(0, LDB, 16'h02);
    issue(0, ADD, 16'h0);
    checks++;
    if ({c8, z8, n8} !== 3'b100) begin
      errors++; $display("FAIL add_flags CZN got=%b exp=100", {c8, z8, n8});
    end
    q8.push_back(16'h01);
    issue(0, OEACC, 16'h0);
    checks++;
    if (ov8 !== 1'b1) begin errors++; $display("FAIL add_out_valid got=%b exp=1", ov8); end
    @(posedge Clk); #1;
    checks++;
    if (ov8 !== 1'b0 || out8 !== 8'h01) begin
      errors++; $display("FAIL add_out_hold valid=%b data=%h exp 0/01", ov8, out8);
    end
  endtask

  task automatic test_sub;
    issue(0, LDA, 16'h05);
    issue(0, LDB, 16'h06);
    issue(0, SUB, 16'h0);
    checks++;
    if ({c8, z8, n8} !== 3'b101) begin
      errors++; $display("FAIL sub_borrow CZN got=%b exp=101", {c8, z8, n8});
    end
    issue(0, NOP15, 16'h0);
    checks++;
    if ({c8, z8, n8} !== 3'b101) begin
      errors++; $display("FAIL nop15_hold CZN got=%b exp=101", {c8, z8, n8});
    end
    q8.push_back(16'hFF);
    issue(0, OEACC, 16'h0);
    issue(0, LDA, 16'h10);
    issue(0, LDB, 16'h10);
    issue(0, SUB, 16'h0);
    checks++;
    if ({c8, z8, n8} !== 3'b010) begin
      errors++; $display("FAIL sub_zero CZN got=%b exp=010", {c8, z8, n8});
    end
    issue(0, CMP, 16'h0);
    checks++;
    if (e8 !== 1'b1 || z8 !== 1'b1) begin
      errors++; $display("FAIL cmp_equal E=%b Z=%b exp 1/1", e8, z8);
    end
  endtask

  task automatic test_logic_shift;
    issue(0, LDA, 16'hF0);
    issue(0, LDB, 16'h3C);
    issue(0, SHL, 16'h0);
    checks++;
    if ({c8, z8, n8} !== 3'b101) begin
      errors++; $display("FAIL shl8 CZN got=%b exp=101", {c8, z8, n8});
    end
    q8.push_back(16'hE0);
    issue(0, OEACC, 16'h0);
    issue(0, ANDO, 16'h0);
    checks++;
    if ({c8, z8, n8} !== 3'b100) begin
      errors++; $display("FAIL and_c_hold CZN got=%b exp=100", {c8, z8, n8});
    end
    q8.push_back(16'h30);
    issue(0, OEACC, 16'h0);
    issue(0, ORO, 16'h0);
    q8.push_back(16'hFC);
    issue(0, OEACC, 16'h0);
    issue(0, XORO, 16'h0);
    checks++;
    if ({c8, n8} !== 2'b11) begin
      errors++; $display("FAIL xor CN got=%b exp=11", {c8, n8});
    end
    q8.push_back(16'hCC);
    issue(0, OEACC, 16'h0);
    issue(0, SHR, 16'h0);
    checks++;
    if ({c8, z8, n8} !== 3'b000) begin
      errors++; $display("FAIL shr8 CZN got=%b exp=000", {c8, z8, n8});
    end
    q8.push_back(16'h78);
    issue(0, OEACC, 16'h0);
  endtask

  task automatic test_mul8;
    int cyc;
    int busy_n;
    issue(0, LDA, 16'hFF);
    issue(0, LDB, 16'hFF);
    issue(0, MUL, 16'h0);
    cyc = 0;
    busy_n = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) busy_n++;
      if (cyc == 2) begin v8 = 1'b1; op8 = LDA; d8 = 8'h33; end
      if (cyc == 3) begin
        checks++;
        if (drop8 !== 1'b1) begin errors++; $display("FAIL mul_op_drop got=%b exp=1", drop8); end
        v8 = 1'b0;
      end
      @(posedge Clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 8 || busy_n != 8) begin
      errors++; $display("FAIL mul8_latency done_after=%0d busy=%0d exp 8/8", cyc, busy_n);
    end
    checks++;
    if ({c8, z8, n8, busy8} !== 4'b1010) begin
      errors++; $display("FAIL mul8_flags CZN,Busy got=%b exp=1010", {c8, z8, n8, busy8});
    end
    q8.push_back(16'h01);
    issue(0, OEACC, 16'h0);
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", done8); end
    q8.push_back(16'hFE);
    issue(0, OEACCH, 16'h0);
    issue(0, CMP, 16'h0);
    checks++;
    if (e8 !== 1'b1) begin errors++; $display("FAIL mul_operand_stable E=%b exp=1", e8); end
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    issue(0, LDA, 16'h05);
    issue(0, LDB, 16'h07);
    issue(0, MUL, 16'h0);
    repeat (2) @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, z8, c8, n8, e8} !== 6'b000000) begin
      errors++; $display("FAIL rst_mid_mul got=%b exp=000000", {busy8, done8, z8, c8, n8, e8});
    end
    @(negedge Clk);
    Rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_no_done seen=%0d exp=0", seen); end
    q8.push_back(16'h00);
    issue(0, OEACC, 16'h0);
    q8.push_back(16'h00);
    issue(0, OEACCH, 16'h0);
  endtask

  task automatic test_w16;
    int cyc;
    int busy_n;
    issue(1, LDA, 16'h8001);
    issue(1, SHL, 16'h0);
    checks++;
    if ({c16, z16, n16} !== 3'b100) begin
      errors++; $display("FAIL shl16 CZN got=%b exp=100", {c16, z16, n16});
    end
    q16.push_back(16'h0002);
    issue(1, OEACC, 16'h0);
    issue(1, SHR, 16'h0);
    checks++;
    if ({c16, n16} !== 2'b10) begin
      errors++; $display("FAIL shr16 CN got=%b exp=10", {c16, n16});
    end
    q16.push_back(16'h4000);
    issue(1, OEACC, 16'h0);
    issue(1, LDA, 16'h1234);
    issue(1, LDB, 16'h0010);
    issue(1, MUL, 16'h0);
    wait_done(1, cyc, busy_n);
    checks++;
    if (cyc != 16 || busy_n != 16) begin
      errors++; $display("FAIL mul16_latency done_after=%0d busy=%0d exp 16/16", cyc, busy_n);
    end
    checks++;
    if ({c16, z16, n16} !== 3'b100) begin
      errors++; $display("FAIL mul16_flags CZN got=%b exp=100", {c16, z16, n16});
    end
    q16.push_back(16'h2340);
    issue(1, OEACC, 16'h0);
    q16.push_back(16'h0001);
    issue(1, OEACCH, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge Clk);
    #1;
    test_reset();
    Rst = 1'b0;
    test_add();
    test_sub();
    test_logic_shift();
    test_mul8();
    test_reset_mid_mul();
    test_w16();
    repeat (3) @(negedge Clk);
    checks++;
    if (q8.size() != 0 || q16.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d/%0d exp=0/0", q8.size(), q16.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
